// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the 8-bit CPU controller: opcodes, FSM states, cBus source
// and ALU operation encodings, the decoded control word, and a helper that
// flags instructions followed by an operand byte.
// Optional build macro used by the importing files: IRQ_EN.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
        OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_LD   = 4'h8, OP_ST  = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
        OP_JNZ  = 4'hC, OP_UND = 4'hD, OP_RETI = 4'hE, OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH, S_FETCH_W, S_DECODE, S_OPR, S_OPR_W, S_EXEC, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CBUS_RF_A = 3'd0, CBUS_ALU = 3'd1, CBUS_OPR = 3'd2,
        CBUS_MEM  = 3'd3, CBUS_CTRL = 3'd4
    } cbus_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
        ALU_OR  = 3'd3, ALU_XOR = 3'd4, ALU_PASS = 3'd5
    } alu_op_e;

    // Everything the EXEC cycle needs to know about the latched instruction.
    typedef struct packed {
        logic       rf_we;
        logic [1:0] rf_waddr;
        logic [1:0] rf_raddr_a;
        logic [1:0] rf_raddr_b;
        cbus_src_e  cbus_src;
        alu_op_e    alu_op;
        logic       flag_we;
        logic       mem_we;
        logic       jmp;
        logic       jz;
        logic       jnz;
        logic       reti;
        logic       hlt;
    } ctrl_word_t;

    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the latched IR byte onto the
// control word applied during EXEC. Branch conditions are resolved by the FSM.
// Ports: ir (latched instruction byte), cw (decoded control word).
// Build macro: IRQ_EN (RETI is decoded only when defined; otherwise a NOP).
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0]  ir,
    output ctrl_word_t  cw
);

    logic [1:0] rd, rs;
    assign rd = ir[3:2];
    assign rs = ir[1:0];

    always_comb begin
        cw = '0;
        case (ir[7:4])
            OP_LDI: begin
                cw.rf_we = 1'b1; cw.rf_waddr = rd; cw.cbus_src = CBUS_OPR;
            end
            OP_MOV: begin
                cw.rf_we = 1'b1; cw.rf_waddr = rd; cw.rf_raddr_a = rs;
                cw.cbus_src = CBUS_RF_A;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                cw.rf_we      = 1'b1;
                cw.rf_waddr   = rd;
                cw.rf_raddr_a = rd;
                cw.rf_raddr_b = rs;
                cw.cbus_src   = CBUS_ALU;
                cw.flag_we    = 1'b1;
                case (ir[7:4])
                    OP_SUB:  cw.alu_op = ALU_SUB;
                    OP_AND:  cw.alu_op = ALU_AND;
                    OP_OR:   cw.alu_op = ALU_OR;
                    OP_XOR:  cw.alu_op = ALU_XOR;
                    default: cw.alu_op = ALU_ADD;
                endcase
            end
            OP_LD: begin
                cw.rf_we = 1'b1; cw.rf_waddr = rd; cw.rf_raddr_a = rs;
                cw.cbus_src = CBUS_MEM;
            end
            OP_ST: begin
                cw.mem_we = 1'b1; cw.rf_raddr_a = rd; cw.rf_raddr_b = rs;
            end
            OP_JMP:  cw.jmp = 1'b1;
            OP_JZ:   cw.jz  = 1'b1;
            OP_JNZ:  cw.jnz = 1'b1;
`ifdef IRQ_EN
            OP_RETI: cw.reti = 1'b1;
`endif
            OP_HLT:  cw.hlt = 1'b1;
            default: ;  // NOP, undefined 4'hD
        endcase
    end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Main control FSM of the 8-bit CPU. Sequences fetch / operand fetch / execute,
// owns the PC (pc_sel, write_pc) and drives IR/operand latches, register file,
// ALU, data memory and the cBus source select.
// Ports: clk, rstn (sync active-low); instr_in (ROM data), pc_in (current PC),
//   zero_flag, irq (IRQ_EN only); pc_sel, write_pc, ir_write, opr_write,
//   cbus_src, ctrl_data, rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op,
//   flag_we, mem_we, halted.
// Build macro: IRQ_EN enables the level interrupt with a single-level EPC.
module instr_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT   = 1,
    parameter logic [7:0]  IRQ_VECTOR = 8'hF0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] instr_in,
    input  logic [7:0] pc_in,
    input  logic       zero_flag,
`ifdef IRQ_EN
    input  logic       irq,
`endif
    output logic       pc_sel,
    output logic       write_pc,
    output logic       ir_write,
    output logic       opr_write,
    output logic [2:0] cbus_src,
    output logic [7:0] ctrl_data,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic [2:0] alu_op,
    output logic       flag_we,
    output logic       mem_we,
    output logic       halted
);

    // Wait counter is preloaded with MEM_WAIT-1 and captures when it hits 0.
    localparam logic [2:0] WAIT_INIT = 3'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] ir_q;
    ctrl_word_t cw;
    logic       irq_take;

    instr_decode u_dec (.ir(ir_q), .cw(cw));

`ifdef IRQ_EN
    logic [7:0] epc_q, epc_d;
    logic       in_isr_q, in_isr_d;
    assign irq_take = irq && !in_isr_q;
`else
    assign irq_take = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{pc_in, IRQ_VECTOR};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            ir_q     <= '0;
`ifdef IRQ_EN
            epc_q    <= '0;
            in_isr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (ir_write) ir_q <= instr_in;
`ifdef IRQ_EN
            epc_q    <= epc_d;
            in_isr_q <= in_isr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_sel     = 1'b0;
        write_pc   = 1'b0;
        ir_write   = 1'b0;
        opr_write  = 1'b0;
        cbus_src   = CBUS_RF_A;
        ctrl_data  = 8'h00;
        rf_we      = 1'b0;
        rf_waddr   = 2'd0;
        rf_raddr_a = 2'd0;
        rf_raddr_b = 2'd0;
        alu_op     = ALU_ADD;
        flag_we    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
`ifdef IRQ_EN
        epc_d      = epc_q;
        in_isr_d   = in_isr_q;
`endif
        // Outputs are gated by rstn so an abandoned instruction issues no writes.
        if (rstn) begin
            case (state_q)
                S_FETCH, S_HALT: begin
                    if (state_q == S_HALT) halted = 1'b1;
                    if (irq_take) begin
                        // Instruction boundary: vector to the ISR instead of fetching.
                        pc_sel   = 1'b1;
                        write_pc = 1'b1;
                        cbus_src = CBUS_CTRL;
                        state_d  = S_FETCH;
`ifdef IRQ_EN
                        ctrl_data = IRQ_VECTOR;
                        epc_d     = pc_in;
                        in_isr_d  = 1'b1;
`endif
                    end else if (state_q == S_FETCH) begin
                        if (MEM_WAIT == 0) begin
                            ir_write = 1'b1;
                            write_pc = 1'b1;
                            state_d  = S_DECODE;
                        end else begin
                            cnt_d   = WAIT_INIT;
                            state_d = S_FETCH_W;
                        end
                    end
                end
                S_FETCH_W: begin
                    if (cnt_q == 3'd0) begin
                        ir_write = 1'b1;
                        write_pc = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_DECODE: state_d = is_two_byte(ir_q[7:4]) ? S_OPR : S_EXEC;
                S_OPR: begin
                    if (MEM_WAIT == 0) begin
                        opr_write = 1'b1;
                        write_pc  = 1'b1;
                        state_d   = S_EXEC;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_OPR_W;
                    end
                end
                S_OPR_W: begin
                    if (cnt_q == 3'd0) begin
                        opr_write = 1'b1;
                        write_pc  = 1'b1;
                        state_d   = S_EXEC;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_EXEC: begin
                    rf_we      = cw.rf_we;
                    rf_waddr   = cw.rf_waddr;
                    rf_raddr_a = cw.rf_raddr_a;
                    rf_raddr_b = cw.rf_raddr_b;
                    cbus_src   = cw.cbus_src;
                    alu_op     = cw.alu_op;
                    flag_we    = cw.flag_we;
                    mem_we     = cw.mem_we;
                    state_d    = cw.hlt ? S_HALT : S_FETCH;
                    if (cw.jmp || (cw.jz && zero_flag) || (cw.jnz && !zero_flag)) begin
                        cbus_src = CBUS_OPR;
                        pc_sel   = 1'b1;
                        write_pc = 1'b1;
                    end
`ifdef IRQ_EN
                    if (cw.reti) begin
                        ctrl_data = epc_q;
                        cbus_src  = CBUS_CTRL;
                        pc_sel    = 1'b1;
                        write_pc  = 1'b1;
                        in_isr_d  = 1'b0;
                    end
`endif
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule
